// File: rtl/ondra_audio_mixer.sv
// rtl/ondra_audio_mixer.sv - time-multiplexed gain/mute audio mixer with saturation
// One channel is accumulated per clk_sys cycle; one registered sample is emitted per accepted sample_ce.
module ondra_audio_mixer #(
   parameter int NUM_CH     = 4,
   parameter int IN_W       = 14,
   parameter int GAIN_W     = 4,
   parameter int SHIFT      = 4,
   parameter int OUT_W      = 16,
   parameter bit SIGNED_OUT = 1'b0
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     sample_ce,
   input  logic [NUM_CH*IN_W-1:0]   ch_data,
   input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
   input  logic [NUM_CH-1:0]        ch_mute,
   output logic [OUT_W-1:0]         audio_out,
   output logic                     audio_valid,
   output logic                     busy,
   output logic                     clip,
   output logic                     overrun
);

   localparam int EXT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = IN_W + GAIN_W;
   localparam int ACC_W  = PROD_W + EXT_W;
   localparam int IDX_W  = EXT_W;
   // Widen the shifted sum so the saturation test always has at least one bit above OUT_W.
   localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
   localparam logic [OUT_W-1:0] MSB_MASK = SIGNED_OUT ? (OUT_W'(1) << (OUT_W - 1)) : '0;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [IN_W-1:0]     r_data [NUM_CH];
   logic [GAIN_W-1:0]   r_gain [NUM_CH];
   logic [NUM_CH-1:0]   r_mute;
   logic [IDX_W-1:0]    r_idx;
   logic [ACC_W-1:0]    r_acc;
   logic [OUT_W-1:0]    r_audio_out;
   logic                r_valid;
   logic                r_clip;
   logic                r_overrun;

   logic                w_load;
   logic                w_acc_en;
   logic                w_emit;
   logic                w_last;
   logic                w_ovr_set;
   logic [PROD_W-1:0]   w_prod;
   logic [PROD_W-1:0]   w_term;
   logic [SAT_W-1:0]    w_shifted;
   logic                w_sat;
   logic [OUT_W-1:0]    w_sample;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (sample_ce) w_next = S_ACC;
         S_ACC:   if (w_last)    w_next = S_OUT;
         S_OUT:                  w_next = S_IDLE;
         default:                w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load    = 1'b0;
      w_acc_en  = 1'b0;
      w_emit    = 1'b0;
      w_ovr_set = 1'b0;
      case (r_state)
         S_IDLE:  w_load = sample_ce;
         S_ACC: begin
            w_acc_en  = 1'b1;
            w_ovr_set = sample_ce;
         end
         S_OUT: begin
            w_emit    = 1'b1;
            w_ovr_set = sample_ce;
         end
         default: ;
      endcase
   end

   assign w_last    = (r_idx == IDX_W'(NUM_CH - 1));
   assign w_prod    = PROD_W'(r_data[r_idx]) * PROD_W'(r_gain[r_idx]);
   assign w_term    = r_mute[r_idx] ? '0 : w_prod;
   assign w_shifted = SAT_W'(r_acc >> SHIFT);
   assign w_sat     = |w_shifted[SAT_W-1:OUT_W];
   assign w_sample  = (w_sat ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0]) ^ MSB_MASK;

   // Snapshot registers isolate the round from input changes after the accepting edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_data[i] <= '0;
            r_gain[i] <= '0;
         end
         r_mute <= '0;
         r_idx  <= '0;
         r_acc  <= '0;
      end else if (w_load) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_data[i] <= ch_data[i*IN_W +: IN_W];
            r_gain[i] <= ch_gain[i*GAIN_W +: GAIN_W];
         end
         r_mute <= ch_mute;
         r_idx  <= '0;
         r_acc  <= '0;
      end else if (w_acc_en) begin
         r_acc <= r_acc + ACC_W'(w_term);
         if (!w_last) r_idx <= r_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_audio_out <= '0;
         r_valid     <= 1'b0;
         r_clip      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_valid <= w_emit;
         if (w_emit) begin
            r_audio_out <= w_sample;
            r_clip      <= w_sat;
         end
         if (w_ovr_set) r_overrun <= 1'b1;
      end
   end

   assign audio_out   = r_audio_out;
   assign audio_valid = r_valid;
   assign clip        = r_clip;
   assign overrun     = r_overrun;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ondra_audio_mixer.sv
// tb/tb_ondra_audio_mixer.sv - directed bench for ondra_audio_mixer
// Three instances share stimulus: defaults, SHIFT=2, and SIGNED_OUT=1.
module tb_ondra_audio_mixer;

   localparam int NUM_CH = 4;
   localparam int IN_W   = 14;
   localparam int GAIN_W = 4;
   localparam int OUT_W  = 16;

   logic                     clk_sys = 1'b0;
   logic                     reset;
   logic                     sample_ce;
   logic [NUM_CH*IN_W-1:0]   ch_data;
   logic [NUM_CH*GAIN_W-1:0] ch_gain;
   logic [NUM_CH-1:0]        ch_mute;

   logic [OUT_W-1:0] out_a, out_b, out_c;
   logic valid_a, valid_b, valid_c;
   logic busy_a, busy_b, busy_c;
   logic clip_a, clip_b, clip_c;
   logic ovr_a, ovr_b, ovr_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_sys = ~clk_sys;

   ondra_audio_mixer u_dut_a (
      .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce),
      .ch_data(ch_data), .ch_gain(ch_gain), .ch_mute(ch_mute),
      .audio_out(out_a), .audio_valid(valid_a), .busy(busy_a),
      .clip(clip_a), .overrun(ovr_a)
   );

   ondra_audio_mixer #(.SHIFT(2)) u_dut_b (
      .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce),
      .ch_data(ch_data), .ch_gain(ch_gain), .ch_mute(ch_mute),
      .audio_out(out_b), .audio_valid(valid_b), .busy(busy_b),
      .clip(clip_b), .overrun(ovr_b)
   );

   ondra_audio_mixer #(.SIGNED_OUT(1'b1)) u_dut_c (
      .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce),
      .ch_data(ch_data), .ch_gain(ch_gain), .ch_mute(ch_mute),
      .audio_out(out_c), .audio_valid(valid_c), .busy(busy_c),
      .clip(clip_c), .overrun(ovr_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int i, input logic [IN_W-1:0] d, input logic [GAIN_W-1:0] g);
      ch_data[i*IN_W +: IN_W]     = d;
      ch_gain[i*GAIN_W +: GAIN_W] = g;
   endtask

   task automatic run_round(input string tag,
                            input logic [OUT_W-1:0] exp_a, input logic exp_clip_a,
                            input logic [OUT_W-1:0] exp_b, input logic exp_clip_b,
                            input logic [OUT_W-1:0] exp_c);
      int lat;
      int busy_cnt;
      lat = 0;
      @(negedge clk_sys) sample_ce = 1'b1;
      @(negedge clk_sys) sample_ce = 1'b0;
      busy_cnt = int'(busy_a);
      while (!valid_a && lat < 20) begin
         @(negedge clk_sys);
         lat++;
         if (!valid_a) busy_cnt += int'(busy_a);
      end
      check({tag, " latency"}, lat, 5);
      check({tag, " busy_cycles"}, busy_cnt, 5);
      check({tag, " busy_low_at_valid"}, busy_a, 0);
      check({tag, " valid_b"}, valid_b, 1);
      check({tag, " out_a"}, out_a, exp_a);
      check({tag, " clip_a"}, clip_a, exp_clip_a);
      check({tag, " out_b"}, out_b, exp_b);
      check({tag, " clip_b"}, clip_b, exp_clip_b);
      check({tag, " out_c"}, out_c, exp_c);
      @(negedge clk_sys);
      check({tag, " valid_drop"}, valid_a, 0);
      check({tag, " out_hold"}, out_a, exp_a);
   endtask

   initial begin
      int pulses;
      logic [OUT_W-1:0] cap;

      reset     = 1'b1;
      sample_ce = 1'b0;
      ch_data   = '0;
      ch_gain   = '0;
      ch_mute   = '0;
      repeat (3) @(negedge clk_sys);
      check("rst out", out_a, 0);
      check("rst valid", valid_a, 0);
      check("rst busy", busy_a, 0);
      check("rst clip", clip_a, 0);
      check("rst overrun", ovr_a, 0);
      check("rst out_c", out_c, 0);
      reset = 1'b0;

      set_ch(0, 14'h1000, 4'd8);
      run_round("single", 16'h0800, 1'b0, 16'h2000, 1'b0, 16'h8800);

      for (int i = 0; i < NUM_CH; i++) set_ch(i, 14'h3FFF, 4'd15);
      run_round("full", 16'hEFFC, 1'b0, 16'hFFFF, 1'b1, 16'h6FFC);

      for (int i = 0; i < NUM_CH; i++) set_ch(i, 14'h0000, 4'd15);
      run_round("zero", 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h8000);

      set_ch(0, 14'h2000, 4'd4);
      set_ch(1, 14'h2000, 4'd4);
      ch_mute = 4'b0010;
      run_round("mute1", 16'h0800, 1'b0, 16'h2000, 1'b0, 16'h8800);
      ch_mute = 4'b0000;
      run_round("nomute", 16'h1000, 1'b0, 16'h4000, 1'b0, 16'h9000);
      check("overrun_clear", ovr_a, 0);

      // Overrun: second strobe two cycles later, data changed after the snapshot edge
      set_ch(0, 14'h1000, 4'd8);
      set_ch(1, 14'h0000, 4'd0);
      pulses = 0;
      cap    = '0;
      @(negedge clk_sys) sample_ce = 1'b1;
      @(negedge clk_sys) begin
         sample_ce = 1'b0;
         set_ch(0, 14'h3FFF, 4'd15);
      end
      @(negedge clk_sys) sample_ce = 1'b1;
      @(negedge clk_sys) sample_ce = 1'b0;
      for (int n = 0; n < 15; n++) begin
         if (valid_a) begin
            pulses++;
            cap = out_a;
         end
         @(negedge clk_sys);
      end
      check("ovr pulses", pulses, 1);
      check("ovr snapshot_out", cap, 16'h0800);
      check("ovr flag", ovr_a, 1);
      check("ovr flag_sticky_c", ovr_c, 1);

      // Reset mid-round
      set_ch(0, 14'h1000, 4'd8);
      @(negedge clk_sys) sample_ce = 1'b1;
      @(negedge clk_sys) sample_ce = 1'b0;
      @(negedge clk_sys) reset = 1'b1;
      @(negedge clk_sys);
      check("midrst out", out_a, 0);
      check("midrst busy", busy_a, 0);
      check("midrst valid", valid_a, 0);
      check("midrst overrun", ovr_a, 0);
      reset = 1'b0;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk_sys);
         if (valid_a) pulses++;
      end
      check("midrst no_pulse", pulses, 0);
      check("midrst out_after", out_a, 0);

      run_round("after_rst", 16'h0800, 1'b0, 16'h2000, 1'b0, 16'h8800);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
